// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One bit per cycle: shift-add for
// multiply and restoring division for divide, on operand magnitudes.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state;
    state_t      nextState;

    logic [2:0]  opReg;
    logic [4:0]  rdReg;
    logic [4:0]  iterCount;
    logic        negHi;
    logic        negLo;

    logic [63:0] prodAcc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [31:0] remReg;
    logic [31:0] quotReg;
    logic [31:0] divisorReg;

    logic        isDivIn;
    logic        aSignedIn;
    logic        bSignedIn;
    logic        aNegIn;
    logic        bNegIn;
    logic [31:0] magA;
    logic [31:0] magB;
    logic        divZero;
    logic        divOverflow;
    logic        fastPath;
    logic [31:0] fastResult;

    logic [63:0] prodStep;
    logic [63:0] prodFinal;
    logic [32:0] trial;
    logic [32:0] trialDiff;
    logic        canSub;
    logic [31:0] remStep;
    logic [31:0] quotStep;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;
    logic [31:0] mulResult;
    logic [31:0] divResult;
    logic        lastIter;

    // Operand decode at accept time: signedness, magnitudes and the divide fast paths.
    always_comb begin
        isDivIn     = funct3[2];
        aSignedIn   = isDivIn ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        bSignedIn   = isDivIn ? ~funct3[0] : (funct3[1:0] == 2'b01);
        aNegIn      = aSignedIn & op_a[31];
        bNegIn      = bSignedIn & op_b[31];
        magA        = aNegIn ? (~op_a + 32'd1) : op_a;
        magB        = bNegIn ? (~op_b + 32'd1) : op_b;
        divZero     = isDivIn && (op_b == 32'h0000_0000);
        divOverflow = isDivIn && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        fastPath    = divZero || divOverflow;
        if (divZero) begin
            fastResult = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else begin
            fastResult = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // One iteration of each datapath, plus the sign-corrected final values.
    always_comb begin
        prodStep  = prodAcc + (mplier[0] ? mcand : 64'd0);
        prodFinal = negHi ? (~prodStep + 64'd1) : prodStep;
        mulResult = (opReg == 3'b000) ? prodFinal[31:0] : prodFinal[63:32];

        trial     = {remReg, quotReg[31]};
        trialDiff = trial - {1'b0, divisorReg};
        canSub    = ~trialDiff[32];
        remStep   = canSub ? trialDiff[31:0] : trial[31:0];
        quotStep  = {quotReg[30:0], canSub};
        quotFinal = negHi ? (~quotStep + 32'd1) : quotStep;
        remFinal  = negLo ? (~remStep + 32'd1) : remStep;
        divResult = opReg[1] ? remFinal : quotFinal;

        lastIter  = (iterCount == 5'd31);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = fastPath ? DONE : CALC;
                end
            end
            CALC: begin
                if (lastIter) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Both datapaths are loaded and stepped together; opReg selects which one is reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            opReg      <= 3'b000;
            rdReg      <= 5'd0;
            iterCount  <= 5'd0;
            negHi      <= 1'b0;
            negLo      <= 1'b0;
            prodAcc    <= 64'd0;
            mcand      <= 64'd0;
            mplier     <= 32'd0;
            remReg     <= 32'd0;
            quotReg    <= 32'd0;
            divisorReg <= 32'd0;
            result     <= 32'd0;
            rd_out     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg      <= funct3;
                        rdReg      <= rd_in;
                        iterCount  <= 5'd0;
                        negHi      <= aNegIn ^ bNegIn;
                        negLo      <= aNegIn;
                        prodAcc    <= 64'd0;
                        mcand      <= {32'd0, magA};
                        mplier     <= magB;
                        remReg     <= 32'd0;
                        quotReg    <= magA;
                        divisorReg <= magB;
                        if (fastPath) begin
                            result <= fastResult;
                            rd_out <= rd_in;
                        end
                    end
                end
                CALC: begin
                    iterCount <= iterCount + 5'd1;
                    prodAcc   <= prodStep;
                    mcand     <= {mcand[62:0], 1'b0};
                    mplier    <= {1'b0, mplier[31:1]};
                    remReg    <= remStep;
                    quotReg   <= quotStep;
                    if (lastIter) begin
                        result <= opReg[2] ? divResult : mulResult;
                        rd_out <= rdReg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
